// File: rtl/device_uart_rx_if.sv
// Shared memory-mapped bus used by the UART devices.
// The CPU side drives ren/wen/wdata; the device returns registered rdata.
interface bus_if;
    logic        ren;
    logic [3:0]  wen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport slave  (input ren, input wen, input wdata, output rdata);
    modport master (output ren, output wen, output wdata, input rdata);
endinterface

// File: rtl/device_uart_rx.sv
// UART receiver: 8N1 frames sampled with a fractional 16x oversample tick, bytes buffered
// in a FIFO that the CPU drains over the bus along with read-to-clear error flags.
module device_uart_rx #(
    parameter int ADDR_WIDTH = 4,
    parameter int ACC_WIDTH  = 20,
    parameter int OVS_INC    = 3216
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  RxD,
    output logic  irq,
    bus_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ACC_WIDTH:0]  OVS_STEP   = (ACC_WIDTH + 1)'(OVS_INC);
    localparam logic [ADDR_WIDTH:0] DEPTH_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_e;

    rxState_e              state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0]            bidx_q, bidx_d;
    logic [7:0]            sreg_q, sreg_d;
    logic                  rxMeta_q, rxSync_q;
    logic [ACC_WIDTH:0]    acc_q, acc_d;
    logic [ADDR_WIDTH:0]   wPtr_q, wPtr_d;
    logic [ADDR_WIDTH:0]   rPtr_q, rPtr_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [7:0]            mem [DEPTH];

    logic                  tick;
    logic                  rxS;
    logic                  stopOk;
    logic                  stopBad;
    logic                  fifoEmpty;
    logic                  fifoFull;
    logic                  flush;
    logic                  pop;
    logic                  push;
    logic                  ovrSet;
    logic [7:0]            headByte;
    logic                  unusedWdata;

    assign unusedWdata = ^bus.wdata[31:1];

    assign tick  = acc_q[ACC_WIDTH];
    assign rxS   = rxSync_q;
    assign acc_d = {1'b0, acc_q[ACC_WIDTH-1:0]} + OVS_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            acc_q    <= '0;
        end else begin
            rxMeta_q <= RxD;
            rxSync_q <= rxMeta_q;
            acc_q    <= acc_d;
        end
    end

    // Frame FSM: start detection is immediate, all bit timing counts oversample ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        sreg_d  = sreg_q;
        stopOk  = 1'b0;
        stopBad = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxS) begin
                    state_d = START;
                    cnt_d   = 4'd0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_q == 4'd7) begin
                        if (!rxS) begin
                            state_d = DATA;
                            cnt_d   = 4'd0;
                            bidx_d  = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == 4'd15) begin
                        sreg_d = {rxS, sreg_q[7:1]};
                        cnt_d  = 4'd0;
                        bidx_d = bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt_q == 4'd15) begin
                        stopOk  = rxS;
                        stopBad = !rxS;
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            sreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            sreg_q  <= sreg_d;
        end
    end

    assign fifoEmpty = (wPtr_q == rPtr_q);
    assign fifoFull  = ((wPtr_q - rPtr_q) == DEPTH_FULL);
    assign headByte  = mem[rPtr_q[ADDR_WIDTH-1:0]];

    // A pop in the same cycle frees the slot for a push; a flush discards the incoming byte.
    always_comb begin
        flush   = (|bus.wen) && bus.wdata[0];
        pop     = bus.ren && !fifoEmpty;
        push    = stopOk && !flush && (!fifoFull || pop);
        ovrSet  = stopOk && !flush && fifoFull && !pop;
        wPtr_d  = wPtr_q + {{ADDR_WIDTH{1'b0}}, push};
        rPtr_d  = flush ? wPtr_q : (rPtr_q + {{ADDR_WIDTH{1'b0}}, pop});
        ferr_d  = stopBad | (ferr_q & ~bus.ren);
        ovr_d   = ovrSet  | (ovr_q  & ~bus.ren);
        rdata_d = rdata_q;
        if (bus.ren) begin
            rdata_d = {21'd0, ovr_q, ferr_q, !fifoEmpty, (fifoEmpty ? 8'h00 : headByte)};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wPtr_q[ADDR_WIDTH-1:0]] <= sreg_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wPtr_q  <= '0;
            rPtr_q  <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            wPtr_q  <= wPtr_d;
            rPtr_q  <= rPtr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign irq       = !fifoEmpty | ferr_q | ovr_q;

endmodule
